// File: rtl/load_store_unit_if.sv
// Core-request and memory-bus signals of the load/store unit, bundled as one interface.
// The unit connects through the slave modport; the core/memory environment uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding B/HW/W access on a req/gnt/rvalid bus with a WAIT timeout.
// Macro LSU_MISALIGN_TRAP_EN: fault misaligned HW/W accesses instead of truncating the offset.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapMisalign = 1'b1;
`else
    localparam bit TrapMisalign = 1'b0;
`endif
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic        rsp_fault_q;
    logic [31:0] rsp_rdata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad_size;
        logic misaligned;
        case (f3)
            3'd0, 3'd1, 3'd2: bad_size = 1'b0;
            3'd4, 3'd5:       bad_size = we;
            default:          bad_size = 1'b1;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return bad_size || (TrapMisalign && misaligned);
    endfunction

    // Misaligned offset bits are dropped so a halfword stays in one half and a word uses all lanes.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << lane_off(size, a);
            2'b01:   return 4'b0011 << lane_off(size, a);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [31:0] s;
        s = d >> {lane_off(f3[1:0], a), 3'b000};
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = store_lanes(funct3_q[1:0], wdata_q);

    // rsp_valid is set only on the transition into RESP, so it lasts exactly that one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (is_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= bus.req_we;
                            mem_be_q  <= byte_en(bus.req_funct3[1:0], bus.req_addr[1:0]);
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= '0;
                        if (we_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_extract(funct3_q, addr_q[1:0], bus.mem_rdata);
                    end else if (cnt_q == TimeoutLast) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small bus responder plus a response scoreboard queue.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_load_store_unit;
    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    rsp_t sb[$];

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one request, plays the memory side (grant after gntDelay REQ cycles, rvalid on
    // the first WAIT cycle if giveRvalid) and checks bus fields, latency and the response.
    // Latency counts the accepting cycle as cycle 1.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int gntDelay, input bit giveRvalid,
                                 input logic [31:0] rdata, input logic [31:0] expRdata,
                                 input bit expFault, input int expReqCycles,
                                 input logic [31:0] expAddr, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input int expLatency,
                                 input string tag);
        rsp_t        exp;
        int          k;
        int          reqCycles;
        int          rspK;
        bit          gntGiven;
        logic [31:0] seenAddr;
        logic [31:0] seenWdata;
        logic [3:0]  seenBe;
        logic        seenWe;
        seenAddr  = '0;
        seenWdata = '0;
        seenBe    = '0;
        seenWe    = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        exp.rdata = expRdata;
        exp.fault = expFault;
        sb.push_back(exp);
        k = 0;
        reqCycles = 0;
        rspK = 0;
        gntGiven = 1'b0;
        while (k < 40 && !(rspK != 0 && k > rspK)) begin
            @(negedge clk);
            k++;
            bus.req_valid  = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (gntGiven && !we && giveRvalid) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
            end
            gntGiven = 1'b0;
            if (bus.mem_req) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    seenAddr  = bus.mem_addr;
                    seenBe    = bus.mem_be;
                    seenWdata = bus.mem_wdata;
                    seenWe    = bus.mem_we;
                end
                bus.mem_gnt = (reqCycles > gntDelay);
                gntGiven    = bus.mem_gnt;
            end else begin
                bus.mem_gnt = 1'b0;
            end
            if (rspK != 0 && k == rspK + 1)
                checkOutput({tag, ".pulse"}, 32'(bus.rsp_valid), 32'd0);
            if (bus.rsp_valid && rspK == 0) begin
                rspK = k;
                checkOutput({tag, ".resp_be"}, 32'(bus.mem_be), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput({tag, ".sb_nonempty"}, 32'd0, 32'd1);
                end else begin
                    exp = sb.pop_front();
                    checkOutput({tag, ".rdata"}, bus.rsp_rdata, exp.rdata);
                    checkOutput({tag, ".fault"}, 32'(bus.rsp_fault), 32'(exp.fault));
                end
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (rspK == 0) begin
            checkOutput({tag, ".rsp_seen"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, ".latency"}, 32'(rspK + 1), 32'(expLatency));
        end
        checkOutput({tag, ".req_cycles"}, 32'(reqCycles), 32'(expReqCycles));
        if (expReqCycles != 0) begin
            checkOutput({tag, ".addr"}, seenAddr, expAddr);
            checkOutput({tag, ".be"}, 32'(seenBe), 32'(expBe));
            checkOutput({tag, ".we"}, 32'(seenWe), 32'(we));
            if (we) checkOutput({tag, ".wdata"}, seenWdata, expWdata);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst.ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst.mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst.mem_be", 32'(bus.mem_be), 32'd0);
        checkOutput("rst.mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 0, 1'b1, 32'h80FF_FF00,
                      32'hFFFF_FF80, 1'b0, 1, 32'h100, 4'b1000, 32'h0, 4, "lb");
        applyStimulus(1'b1, 3'd1, 32'h202, 32'h0000_BEEF, 2, 1'b0, 32'h0,
                      32'h0, 1'b0, 3, 32'h200, 4'b1100, 32'hBEEF_BEEF, 5, "sh");
        applyStimulus(1'b0, 3'd5, 32'h002, 32'h0, 0, 1'b1, 32'h9ABC_1234,
                      32'h0000_9ABC, 1'b0, 1, 32'h000, 4'b1100, 32'h0, 4, "lhu");
        applyStimulus(1'b0, 3'd2, 32'h080, 32'h0, 0, 1'b0, 32'h0,
                      32'h0, 1'b1, 1, 32'h080, 4'b1111, 32'h0, 7, "lw_timeout");
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 3'd2, 32'h001, 32'h0, 0, 1'b1, 32'h1234_5678,
                      32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 2, "lw_misaligned");
        applyStimulus(1'b0, 3'd1, 32'h003, 32'h0, 0, 1'b1, 32'h7FFF_0000,
                      32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 2, "lh_misaligned");
`else
        applyStimulus(1'b0, 3'd2, 32'h001, 32'h0, 0, 1'b1, 32'h1234_5678,
                      32'h1234_5678, 1'b0, 1, 32'h000, 4'b1111, 32'h0, 4, "lw_misaligned");
        applyStimulus(1'b0, 3'd1, 32'h003, 32'h0, 0, 1'b1, 32'h7FFF_0000,
                      32'h0000_7FFF, 1'b0, 1, 32'h000, 4'b1100, 32'h0, 4, "lh_misaligned");
`endif
        applyStimulus(1'b0, 3'd1, 32'h000, 32'h0, 1, 1'b1, 32'h0000_8001,
                      32'hFFFF_8001, 1'b0, 2, 32'h000, 4'b0011, 32'h0, 5, "lh_sign");
        applyStimulus(1'b0, 3'd4, 32'h001, 32'h0, 0, 1'b1, 32'h0000_F000,
                      32'h0000_00F0, 1'b0, 1, 32'h000, 4'b0010, 32'h0, 4, "lbu");
        applyStimulus(1'b1, 3'd2, 32'h010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,
                      32'h0, 1'b0, 1, 32'h010, 4'b1111, 32'hDEAD_BEEF, 3, "sw");
        applyStimulus(1'b1, 3'd0, 32'h005, 32'h1234_56A5, 0, 1'b0, 32'h0,
                      32'h0, 1'b0, 1, 32'h004, 4'b0010, 32'hA5A5_A5A5, 3, "sb");
        applyStimulus(1'b0, 3'd3, 32'h020, 32'h0, 0, 1'b1, 32'h1111_1111,
                      32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 2, "illegal_f3");
        applyStimulus(1'b1, 3'd4, 32'h020, 32'h55, 0, 1'b0, 32'h0,
                      32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 2, "store_bu");

        // Stray read data while idle must not produce a response.
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        repeat (2) begin
            @(negedge clk);
            checkOutput("stray_rvalid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        bus.mem_rvalid = 1'b0;

        // Reset in the middle of a load that is waiting for read data.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h40;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("midrst.mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midrst.mem_addr", bus.mem_addr, 32'd0);
        checkOutput("midrst.ready", 32'(bus.req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst.no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'h007, 32'h0000_005A, 0, 1'b0, 32'h0,
                      32'h0, 1'b0, 1, 32'h004, 4'b1000, 32'h5A5A_5A5A, 3, "sb_after_rst");

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
